frame_arbiter: RTL and testbench
================================

FRAME_ARBITER -- requirements
Module: frame_arbiter

Interface
REQ-001 Parameter N_SRC, default 4, number of frame sources (2..16) that share one framing tx path.
REQ-002 Parameter CNT_W, default 16, width of the completed-frame counter.
REQ-003 aclk  input  1  single clock; all logic on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 s_frame_tvalid  input  N_SRC  per-source AXI4-Stream valid.
REQ-006 s_frame_tready  output  N_SRC  per-source ready.
REQ-007 s_frame_tdata  input  8*N_SRC  per-source byte; source i occupies bits [8i+7:8i].
REQ-008 s_frame_tlast  input  N_SRC  per-source end-of-frame.
REQ-009 m_frame_tvalid / m_frame_tready / m_frame_tdata[7:0] / m_frame_tlast  output/input/output/output  merged stream toward the framing tx_frame port.
REQ-010 grant_id  output  $clog2(N_SRC)  index of the current or most recent granted source.
REQ-011 busy  output  1  high while not in IDLE.
REQ-012 frame_cnt  output  CNT_W  count of completed merged frames.

Function
REQ-013 FSM states: IDLE, HEADER (only with macro), DATA.
- IDLE: all s_frame_tready=0, m_frame_tvalid=0; if any s_frame_tvalid is high, grant the first requester strictly after last_grant in ascending index order with wrap N_SRC-1 -> 0; register grant_id; next state HEADER (macro) or DATA.
- HEADER: m_frame_tvalid=1, m_frame_tdata=grant_id zero-extended to 8 bits, m_frame_tlast=0, all s_frame_tready=0; on m_frame_tvalid&m_frame_tready -> DATA.
- DATA: combinational pass-through of the granted source: m_frame_tvalid=s_frame_tvalid[g], m_frame_tdata/tlast from source g, s_frame_tready[g]=m_frame_tready, all other tready=0; on handshake with tlast=1 -> IDLE, last_grant<=g, frame_cnt increments.
REQ-014 Grant is locked for a whole frame; requests from other sources never interrupt a frame, including when the granted source deasserts tvalid mid-frame.
REQ-015 Data path latency in DATA is zero cycles; each frame costs exactly one IDLE arbitration cycle before its first output beat.
REQ-016 A source's tvalid arriving in the same cycle the current frame ends is considered in the next IDLE cycle, not the current one.
REQ-017 Single requester: it is granted every frame in turn (wrap lands back on itself).
REQ-018 frame_cnt wraps from 2^CNT_W-1 to 0 without saturation.
REQ-019 m_frame_tvalid never depends combinationally on m_frame_tready.

Reset
REQ-020 On aresetn low: state=IDLE, last_grant=N_SRC-1 (first grant goes to source 0), grant_id=0, frame_cnt=0, busy=0, all tready/tvalid outputs 0, m_frame_tdata=0, m_frame_tlast=0.
REQ-021 Reset mid-frame abandons the frame; no tlast is emitted; after release the block arbitrates fresh from IDLE.

Configuration
REQ-022 Macro FRAME_ARBITER_ID_HEADER_EN: when defined, HEADER state exists and every merged frame is prefixed by one source-ID byte; when undefined, HEADER is absent, IDLE goes directly to DATA, frames pass unmodified.

Structure
REQ-023 Package frame_arbiter_pkg holds the state enum type and the header-byte width constant.
REQ-024 One sub-module rr_arbiter (N-way round-robin pick from request vector and last_grant, purely combinational); FSM, mux and counter live in frame_arbiter.

Verification
REQ-025 Src0 sends 3-byte frame 11,22,33 (tlast on 33), others idle -> output 00,11,22,33 with header (11,22,33 without), tlast on 33, frame_cnt=1.
REQ-026 All 4 sources request continuously with 2-byte frames -> grant order 0,1,2,3,0; no interleaving of bytes between frames.
REQ-027 Src1 mid-frame drops tvalid for 5 cycles while src2 requests -> output stalls, src2 tready stays 0, src1 frame completes before src2 header.
REQ-028 Random m_frame_tready backpressure (50%) over 1000 frames -> no byte loss/duplication, per-source byte order preserved, frame_cnt=1000.
REQ-029 aresetn pulsed low during src3 data beat 2 -> all outputs zero immediately; after release with src0 and src3 requesting, src0 granted first.
REQ-030 CNT_W=4, 17 frames -> frame_cnt reads 1 after wrap.

Source files
------------

// File: rtl/frame_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | frame_arbiter_pkg : shared state type and header-byte width            |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package frame_arbiter_pkg;

    localparam int HDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

endpackage : frame_arbiter_pkg
`default_nettype wire

// File: rtl/frame_arbiter_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, first request after last |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest candidate down so the nearest one after i_last wins.
    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        w_cand  = '0;
        for (int k = N; k >= 1; k--) begin
            w_cand = IDX_W'((int'(i_last) + k) % N);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_grant = w_cand;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/frame_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | frame_arbiter : N-source frame-locked round-robin merge onto one stream|
// | Optional source-ID header byte: FRAME_ARBITER_ID_HEADER_EN. Rev 1.0    |
// +-----------------------------------------------------------------------+
module frame_arbiter
    import frame_arbiter_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int CNT_W = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [N_SRC-1:0]         s_frame_tvalid,
    output logic [N_SRC-1:0]         s_frame_tready,
    input  logic [8*N_SRC-1:0]       s_frame_tdata,
    input  logic [N_SRC-1:0]         s_frame_tlast,
    output logic                     m_frame_tvalid,
    input  logic                     m_frame_tready,
    output logic [7:0]               m_frame_tdata,
    output logic                     m_frame_tlast,
    output logic [$clog2(N_SRC)-1:0] grant_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam int IDX_W = $clog2(N_SRC);

    state_t           r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    logic [CNT_W-1:0] r_frame_cnt;

    logic [IDX_W-1:0] w_pick;
    logic             w_pick_valid;
    logic             w_src_valid;
    logic [7:0]       w_src_data;
    logic             w_src_last;
    logic             w_frame_end;

    rr_arbiter #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (s_frame_tvalid),
        .i_last  (r_last_grant),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    assign w_src_valid = s_frame_tvalid[r_grant];
    assign w_src_data  = s_frame_tdata[{r_grant, 3'b000} +: 8];
    assign w_src_last  = s_frame_tlast[r_grant];
    assign w_frame_end = (r_state == ST_DATA) & w_src_valid & m_frame_tready & w_src_last;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(N_SRC - 1);
            r_frame_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick;
`ifdef FRAME_ARBITER_ID_HEADER_EN
                        r_state <= ST_HEADER;
`else
                        r_state <= ST_DATA;
`endif
                    end
                end
`ifdef FRAME_ARBITER_ID_HEADER_EN
                ST_HEADER: begin
                    if (m_frame_tready) begin
                        r_state <= ST_DATA;
                    end
                end
`endif
                ST_DATA: begin
                    // Grant stays locked until the granted source delivers tlast.
                    if (w_frame_end) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= r_grant;
                        r_frame_cnt  <= r_frame_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        m_frame_tvalid = 1'b0;
        m_frame_tdata  = '0;
        m_frame_tlast  = 1'b0;
        s_frame_tready = '0;
        case (r_state)
`ifdef FRAME_ARBITER_ID_HEADER_EN
            ST_HEADER: begin
                m_frame_tvalid = 1'b1;
                m_frame_tdata  = HDR_W'(r_grant);
            end
`endif
            ST_DATA: begin
                m_frame_tvalid          = w_src_valid;
                m_frame_tdata           = w_src_data;
                m_frame_tlast           = w_src_last;
                s_frame_tready[r_grant] = m_frame_tready;
            end
            default: ;
        endcase
    end

    assign grant_id  = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign frame_cnt = r_frame_cnt;

endmodule : frame_arbiter
`default_nettype wire

// File: tb/tb_frame_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_frame_arbiter : directed + randomized-backpressure bench, model-based|
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_frame_arbiter;

    localparam int N = 4;
`ifdef FRAME_ARBITER_ID_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [7:0] gap;
    } beat_t;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [N-1:0]   s_tvalid;
    logic [N-1:0]   s_tlast;
    logic [8*N-1:0] s_tdata;
    logic           m_tready;

    logic [N-1:0]   s_tready, s_tready_s;
    logic           m_tvalid, m_tvalid_s, m_tlast, m_tlast_s;
    logic [7:0]     m_tdata, m_tdata_s;
    logic [1:0]     gid, gid_s;
    logic           busy, busy_s;
    logic [15:0]    cnt;
    logic [3:0]     cnt_s;

    frame_arbiter #(.N_SRC(N), .CNT_W(16)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_frame_tvalid(s_tvalid), .s_frame_tready(s_tready),
        .s_frame_tdata(s_tdata), .s_frame_tlast(s_tlast),
        .m_frame_tvalid(m_tvalid), .m_frame_tready(m_tready),
        .m_frame_tdata(m_tdata), .m_frame_tlast(m_tlast),
        .grant_id(gid), .busy(busy), .frame_cnt(cnt)
    );

    frame_arbiter #(.N_SRC(N), .CNT_W(4)) u_dut4 (
        .aclk(aclk), .aresetn(aresetn),
        .s_frame_tvalid(s_tvalid), .s_frame_tready(s_tready_s),
        .s_frame_tdata(s_tdata), .s_frame_tlast(s_tlast),
        .m_frame_tvalid(m_tvalid_s), .m_frame_tready(m_tready),
        .m_frame_tdata(m_tdata_s), .m_frame_tlast(m_tlast_s),
        .grant_id(gid_s), .busy(busy_s), .frame_cnt(cnt_s)
    );

    always #5 aclk = ~aclk;

    int         n_checks = 0;
    int         n_errors = 0;
    beat_t      src_q[N][$];
    beat_t      exp_q[N][$];
    logic [7:0] out_log[$];
    logic [7:0] exp_log[$];
    int         grant_log[$];
    bit         rnd_ready = 1'b0;
    int         stall_cnt = 0;
    int         early_rdy2 = 0;

    // Reference model: arbitration outcome and frame progress as plain integers.
    bit         md_busy = 1'b0;
    bit         md_hdr = 1'b0;
    int         md_g = 0;
    int         md_last = N - 1;
    int         md_cnt = 0;

    logic           exp_v, exp_l;
    logic [7:0]     exp_d;
    logic [N-1:0]   exp_rdy;
    beat_t          eb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_frame(input int s, input int len, input logic [7:0] first,
                             input logic [7:0] step, input int gap_pos, input int gap_len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d   = first + 8'(k) * step;
            b.l   = (k == len - 1);
            b.gap = (k == gap_pos) ? 8'(gap_len) : 8'd0;
            src_q[s].push_back(b);
            exp_q[s].push_back(b);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        out_log.delete();
        grant_log.delete();
        stall_cnt  = 0;
        early_rdy2 = 0;
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #2;
        aresetn   = 1'b0;
        rnd_ready = 1'b0;
        clear_all();
        repeat (3) @(posedge aclk);
        #2;
        aresetn = 1'b1;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int c = 0;
        while (c < max_cyc && (!all_empty() || md_busy)) begin
            @(posedge aclk);
            c++;
        end
        repeat (2) @(posedge aclk);
        #2;
        chk({name, "_timeout"}, 32'(c >= max_cyc), 32'd0);
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, 32'(out_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < out_log.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(out_log[i]), 32'(exp_log[i]));
    endtask

    // Source drivers: present queue heads, honour gaps, retire accepted beats.
    initial begin
        logic [N-1:0] pop;
        beat_t hb;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        forever begin
            @(negedge aclk);
            pop = s_tvalid & s_tready;
            @(posedge aclk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pop[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                s_tvalid[i]       = 1'b0;
                s_tdata[8*i +: 8] = 8'h00;
                s_tlast[i]        = 1'b0;
                if (src_q[i].size() > 0) begin
                    hb = src_q[i][0];
                    if (hb.gap != 0) begin
                        hb.gap      = hb.gap - 8'd1;
                        src_q[i][0] = hb;
                    end else begin
                        s_tvalid[i]       = 1'b1;
                        s_tdata[8*i +: 8] = hb.d;
                        s_tlast[i]        = hb.l;
                    end
                end
            end
            m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Per-cycle compare against the model, scoreboard, then advance the model.
    always @(negedge aclk) begin
        if (!aresetn) begin
            md_busy = 1'b0;
            md_hdr  = 1'b0;
            md_g    = 0;
            md_last = N - 1;
            md_cnt  = 0;
            n_checks++;
            if ({m_tvalid, m_tdata, m_tlast, s_tready, busy, gid, cnt,
                 m_tvalid_s, m_tdata_s, m_tlast_s, s_tready_s, busy_s, gid_s, cnt_s} != '0) begin
                n_errors++;
                $display("FAIL reset_outputs t=%0t: got v=%b d=%h l=%b rdy=%b busy=%b gid=%0d cnt=%0d cnt4=%0d, expected all zero",
                         $time, m_tvalid, m_tdata, m_tlast, s_tready, busy, gid, cnt, cnt_s);
            end
        end else begin
            exp_v   = 1'b0;
            exp_d   = 8'h00;
            exp_l   = 1'b0;
            exp_rdy = '0;
            if (md_busy && md_hdr) begin
                exp_v = 1'b1;
                exp_d = 8'(md_g);
            end else if (md_busy) begin
                exp_v   = s_tvalid[md_g];
                exp_d   = s_tdata[8*md_g +: 8];
                exp_l   = s_tlast[md_g];
                exp_rdy = m_tready ? (N'(1) << md_g) : '0;
            end
            n_checks++;
            if (m_tvalid !== exp_v || m_tdata !== exp_d || m_tlast !== exp_l ||
                s_tready !== exp_rdy || busy !== md_busy || gid !== 2'(md_g) ||
                cnt !== 16'(md_cnt) || cnt_s !== 4'(md_cnt) ||
                m_tvalid_s !== exp_v || m_tdata_s !== exp_d || m_tlast_s !== exp_l ||
                s_tready_s !== exp_rdy || busy_s !== md_busy || gid_s !== 2'(md_g)) begin
                n_errors++;
                $display("FAIL cycle t=%0t: got v=%b d=%h l=%b rdy=%b busy=%b gid=%0d cnt=%0d cnt4=%0d; expected v=%b d=%h l=%b rdy=%b busy=%b gid=%0d cnt=%0d",
                         $time, m_tvalid, m_tdata, m_tlast, s_tready, busy, gid, cnt, cnt_s,
                         exp_v, exp_d, exp_l, exp_rdy, md_busy, md_g, md_cnt);
            end

            if (busy && !m_tvalid) stall_cnt++;
            if (s_tready[2] && grant_log.size() == 0) early_rdy2++;

            if (m_tvalid && m_tready) begin
                out_log.push_back(m_tdata);
                if (md_busy && !md_hdr) begin
                    n_checks++;
                    if (exp_q[md_g].size() == 0) begin
                        n_errors++;
                        $display("FAIL scoreboard_extra src%0d: got byte %h, expected none", md_g, m_tdata);
                    end else begin
                        eb = exp_q[md_g].pop_front();
                        if (eb.d !== m_tdata || eb.l !== m_tlast) begin
                            n_errors++;
                            $display("FAIL scoreboard src%0d: got %h/last=%b, expected %h/last=%b",
                                     md_g, m_tdata, m_tlast, eb.d, eb.l);
                        end
                    end
                    if (m_tlast) grant_log.push_back(int'(gid));
                end
            end

            if (!md_busy) begin
                for (int k = 1; k <= N; k++) begin
                    if (s_tvalid[(md_last + k) % N]) begin
                        md_g    = (md_last + k) % N;
                        md_busy = 1'b1;
                        md_hdr  = HDR;
                        break;
                    end
                end
            end else if (md_hdr) begin
                if (m_tready) md_hdr = 1'b0;
            end else if (s_tvalid[md_g] && m_tready && s_tlast[md_g]) begin
                md_busy = 1'b0;
                md_last = md_g;
                md_cnt  = md_cnt + 1;
            end
        end
    end

    initial begin
        int c;
        int s;
        // Reset state and single 3-byte frame from source 0.
        do_reset();
        #1;
        chk("reset_cnt", 32'(cnt), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        add_frame(0, 3, 8'h11, 8'h11, -1, 0);
        wait_done("s1", 50);
        exp_log = {8'h11, 8'h22, 8'h33};
        if (HDR) exp_log.push_front(8'h00);
        check_log("s1_out");
        chk("s1_cnt", 32'(cnt), 32'd1);

        // All four sources with two 2-byte frames each.
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < N; i++)
                add_frame(i, 2, 8'(16 * (i + 1) + 4 * f), 8'd1, -1, 0);
        wait_done("s2", 200);
        chk("s2_ngrants", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            chk($sformatf("s2_grant%0d", k), 32'(grant_log[k]), 32'(k % N));
        chk("s2_cnt", 32'(cnt), 32'd8);

        // Source 1 stalls mid-frame while source 2 waits.
        do_reset();
        add_frame(1, 4, 8'hA1, 8'd1, 1, 5);
        add_frame(2, 2, 8'hB1, 8'd1, -1, 0);
        wait_done("s3", 100);
        exp_log.delete();
        if (HDR) exp_log.push_back(8'h01);
        exp_log.push_back(8'hA1); exp_log.push_back(8'hA2);
        exp_log.push_back(8'hA3); exp_log.push_back(8'hA4);
        if (HDR) exp_log.push_back(8'h02);
        exp_log.push_back(8'hB1); exp_log.push_back(8'hB2);
        check_log("s3_out");
        chk("s3_stall", 32'(stall_cnt), 32'd5);
        chk("s3_src2_ready_early", 32'(early_rdy2), 32'd0);

        // Reset during source 3's second beat, then fresh arbitration.
        do_reset();
        add_frame(3, 4, 8'h31, 8'd1, -1, 0);
        c = 0;
        while (c < 30 && !(m_tvalid && m_tdata == 8'h31 && gid == 2'd3)) begin
            @(negedge aclk);
            c++;
        end
        chk("s5_wait_timeout", 32'(c >= 30), 32'd0);
        @(posedge aclk);
        #2;
        chk("s5_beat2", 32'(m_tdata), 32'h32);
        aresetn = 1'b0;
        #1;
        chk("s5_reset_now", {m_tvalid, m_tlast, m_tdata, s_tready, busy, gid, cnt}, 32'd0);
        clear_all();
        add_frame(3, 2, 8'h41, 8'd1, -1, 0);
        add_frame(0, 2, 8'h51, 8'd1, -1, 0);
        repeat (2) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        wait_done("s5", 100);
        chk("s5_ngrants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            chk("s5_first_grant", 32'(grant_log[0]), 32'd0);
            chk("s5_second_grant", 32'(grant_log[1]), 32'd3);
        end

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int f = 0; f < 17; f++) add_frame(0, 1, 8'(f), 8'd1, -1, 0);
        wait_done("s6", 200);
        chk("s6_cnt16", 32'(cnt), 32'd17);
        chk("s6_cnt4_wrapped", 32'(cnt_s), 32'd1);

        // 1000 random frames under 50% backpressure.
        do_reset();
        rnd_ready = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            s = int'($urandom_range(0, N - 1));
            c = int'($urandom_range(1, 4));
            add_frame(s, c, 8'($urandom), 8'($urandom_range(1, 255)),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, c - 1)) : -1,
                      int'($urandom_range(1, 3)));
        end
        wait_done("s4", 40000);
        rnd_ready = 1'b0;
        chk("s4_cnt", 32'(cnt), 32'd1000);
        c = 0;
        for (int i = 0; i < N; i++) c += exp_q[i].size();
        chk("s4_leftover", 32'(c), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_frame_arbiter
`default_nettype wire
